// File: rtl/cr16_pkg.sv
// Shared CR16 datapath constants and types.
package cr16_pkg;

  localparam int unsigned CR16_DATA_WIDTH = 16;
  localparam int unsigned CR16_NUM_REGS   = 16;

  typedef logic [15:0] cr16_word_t;
  typedef logic [3:0]  cr16_reg_addr_t;

endpackage : cr16_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: register select, write bypass and pending mask.
module regfile_read_port
  import cr16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = $bits(cr16_word_t),
  parameter int unsigned NUM_REGS   = CR16_NUM_REGS,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 0,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [NUM_REGS-1:0]                 pending_i,
  input  logic                                wr_en_i,
  input  logic [AW-1:0]                       wr_addr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic [AW-1:0]                       rd_addr_i,
  output logic [DATA_WIDTH-1:0]               rd_data_o,
  output logic                                rd_pending_o
);

  logic wr_to_r0;
  logic bypass_hit;

  // A write to a hard-wired r0 is discarded, so it must never be forwarded.
  always_comb begin
    wr_to_r0   = (ZERO_REG != 0) && (wr_addr_i == '0);
    bypass_hit = (BYPASS != 0) && wr_en_i && !wr_to_r0 && (wr_addr_i == rd_addr_i);
  end

  // Forwarded data is by definition the fresh value, so it is never pending.
  always_comb begin
    rd_data_o    = regs_i[rd_addr_i];
    rd_pending_o = pending_i[rd_addr_i];
    if (bypass_hit) begin
      rd_data_o    = wr_data_i;
      rd_pending_o = 1'b0;
    end
  end

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_RD read ports, pending scoreboard.
module regfile_mp
  import cr16_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = $bits(cr16_word_t),
  parameter int unsigned NUM_REGS   = CR16_NUM_REGS,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 0,
  localparam int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                                I_CLK,
  input  logic                                I_NRESET,
  input  logic                                I_WR_EN,
  input  logic [AW-1:0]                       I_WR_ADDR,
  input  logic [DATA_WIDTH-1:0]               I_WR_DATA,
  input  logic                                I_RSV_EN,
  input  logic [AW-1:0]                       I_RSV_ADDR,
  input  logic [NUM_RD-1:0][AW-1:0]           I_RD_ADDR,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   O_RD_DATA,
  output logic [NUM_RD-1:0]                   O_RD_PENDING,
  output logic [NUM_REGS-1:0]                 O_PENDING,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] O_REG_DATA
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
  logic                                wr_allowed;
  logic                                rsv_allowed;

  // With a hard-wired r0, writes and reservations aimed at it are dropped.
  always_comb begin
    wr_allowed  = I_WR_EN  && !((ZERO_REG != 0) && (I_WR_ADDR  == '0));
    rsv_allowed = I_RSV_EN && !((ZERO_REG != 0) && (I_RSV_ADDR == '0));
  end

  // Next state: write clears pending, reserve applied last so it wins on a
  // same-address collision; reset overrides everything.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_allowed) begin
      regs_d[I_WR_ADDR]    = I_WR_DATA;
      pending_d[I_WR_ADDR] = 1'b0;
    end
    if (rsv_allowed) begin
      pending_d[I_RSV_ADDR] = 1'b1;
    end
    if (!I_NRESET) begin
      regs_d    = '0;
      pending_d = '0;
    end
  end

  // Storage and scoreboard registers.
  always_ff @(posedge I_CLK) begin
    regs_q    <= regs_d;
    pending_q <= pending_d;
  end

  // r0 is never written when hard-wired, so the stored state already reads 0.
  always_comb begin
    O_REG_DATA = regs_q;
    O_PENDING  = pending_q;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .regs_i       (regs_q),
      .pending_i    (pending_q),
      .wr_en_i      (I_WR_EN),
      .wr_addr_i    (I_WR_ADDR),
      .wr_data_i    (I_WR_DATA),
      .rd_addr_i    (I_RD_ADDR[k]),
      .rd_data_o    (O_RD_DATA[k]),
      .rd_pending_o (O_RD_PENDING[k])
    );
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, no-bypass and zero-reg builds.
module tb_regfile_mp;

  logic             clk = 1'b0;
  logic             nrst;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [15:0]      wr_data;
  logic             rsv_en;
  logic [3:0]       rsv_addr;
  logic [1:0][3:0]  rd_addr;

  logic [1:0][15:0]  rd_data,  rd_data_nb,  rd_data_z;
  logic [1:0]        rd_pend,  rd_pend_nb,  rd_pend_z;
  logic [15:0]       pend,     pend_nb,     pend_z;
  logic [15:0][15:0] reg_data, reg_data_nb, reg_data_z;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model of the default build.
  logic [15:0] m_reg [16];
  logic [15:0] m_pend;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic        pend;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .I_CLK(clk), .I_NRESET(nrst), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_RSV_EN(rsv_en), .I_RSV_ADDR(rsv_addr), .I_RD_ADDR(rd_addr),
    .O_RD_DATA(rd_data), .O_RD_PENDING(rd_pend), .O_PENDING(pend), .O_REG_DATA(reg_data)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .I_CLK(clk), .I_NRESET(nrst), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_RSV_EN(rsv_en), .I_RSV_ADDR(rsv_addr), .I_RD_ADDR(rd_addr),
    .O_RD_DATA(rd_data_nb), .O_RD_PENDING(rd_pend_nb), .O_PENDING(pend_nb),
    .O_REG_DATA(reg_data_nb)
  );

  regfile_mp #(.ZERO_REG(1)) u_dut_z (
    .I_CLK(clk), .I_NRESET(nrst), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_RSV_EN(rsv_en), .I_RSV_ADDR(rsv_addr), .I_RD_ADDR(rd_addr),
    .O_RD_DATA(rd_data_z), .O_RD_PENDING(rd_pend_z), .O_PENDING(pend_z),
    .O_REG_DATA(reg_data_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus and queue the expected read-port results.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [3:0] a0, input logic [3:0] a1);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_addr[0] = a0; rd_addr[1] = a1;
    for (int k = 0; k < 2; k++) begin
      e.port = k;
      if (we && wa == rd_addr[k]) begin
        e.data = wd;
        e.pend = 1'b0;
      end else begin
        e.data = m_reg[rd_addr[k]];
        e.pend = m_pend[rd_addr[k]];
      end
      sb_q.push_back(e);
    end
  endtask

  // Mid-cycle: drain the scoreboard and compare full state against the model.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("rd_data[%0d]", e.port), 32'(rd_data[e.port]), 32'(e.data));
      check($sformatf("rd_pend[%0d]", e.port), 32'(rd_pend[e.port]), 32'(e.pend));
    end
    for (int i = 0; i < 16; i++)
      check($sformatf("reg_data[%0d]", i), 32'(reg_data[i]), 32'(m_reg[i]));
    check("pending", 32'(pend), 32'(m_pend));
  endtask

  // Clock edge: advance the model with the inputs that were applied.
  task automatic commit();
    @(posedge clk);
    if (!nrst) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pend = '0;
    end else begin
      if (wr_en) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    commit();
  endtask

  initial begin
    nrst = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0; rd_addr = '0;
    commit();
    nrst = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd1, 4'd2);
    cyc();

    // Fill all registers, then a single reset edge must wipe everything.
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 16'(i * 16'h1111), (i % 3) == 0, 4'(15 - i), 4'(i), 4'(15 - i));
      cyc();
    end
    nrst = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd4, 4'd9);
    cyc();
    nrst = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd4, 4'd9);
    sample();
    check("reset_pending", 32'(pend), 32'h0);
    check("reset_r15", 32'(reg_data[15]), 32'h0);
    commit();

    // Sweep every register through all multiples of 1024.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 64; j++) begin
        drive(1, 4'(i), 16'(j * 1024), 0, 0, 4'(i), 4'($urandom_range(0, 15)));
        cyc();
      end
    end

    // Bypass vs no-bypass on r3.
    drive(1, 4'd3, 16'h00AA, 0, 0, 4'd0, 4'd1);
    cyc();
    drive(1, 4'd3, 16'h5555, 0, 0, 4'd3, 4'd3);
    sample();
    check("nb_same_cycle0", 32'(rd_data_nb[0]), 32'h00AA);
    check("nb_same_cycle1", 32'(rd_data_nb[1]), 32'h00AA);
    commit();
    drive(0, 0, 0, 0, 0, 4'd3, 4'd3);
    sample();
    check("nb_after_edge0", 32'(rd_data_nb[0]), 32'h5555);
    check("nb_after_edge1", 32'(rd_data_nb[1]), 32'h5555);
    commit();

    // Scoreboard on r5: reserve, re-reserve, write clears, write+reserve keeps pending.
    drive(0, 0, 0, 1, 4'd5, 4'd5, 4'd5);
    cyc();
    drive(0, 0, 0, 1, 4'd5, 4'd5, 4'd5);
    sample();
    check("r5_reserved", 32'(rd_pend[0]), 32'h1);
    commit();
    drive(1, 4'd5, 16'h1234, 0, 0, 4'd5, 4'd5);
    sample();
    check("r5_bypass_pend", 32'(rd_pend[1]), 32'h0);
    commit();
    drive(0, 0, 0, 0, 0, 4'd5, 4'd5);
    cyc();
    drive(1, 4'd5, 16'hBEEF, 1, 4'd5, 4'd5, 4'd6);
    cyc();
    drive(0, 0, 0, 0, 0, 4'd5, 4'd6);
    sample();
    check("r5_wr_rsv_data", 32'(reg_data[5]), 32'hBEEF);
    check("r5_wr_rsv_pend", 32'(pend[5]), 32'h1);
    commit();

    // Hard-wired r0 build.
    drive(1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd0, 4'd0);
    sample();
    check("z_bypass_rd0", 32'(rd_data_z[0]), 32'h0);
    check("z_bypass_pend", 32'(rd_pend_z[1]), 32'h0);
    commit();
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0);
    sample();
    check("z_rd0", 32'(rd_data_z[0]), 32'h0);
    check("z_rd1", 32'(rd_data_z[1]), 32'h0);
    check("z_reg0", 32'(reg_data_z[0]), 32'h0);
    check("z_pend0", 32'(pend_z[0]), 32'h0);
    commit();

    // Reset colliding with a write to r7 and a reserve of r2.
    drive(1, 4'd7, 16'hA5A5, 1, 4'd2, 4'd7, 4'd2);
    cyc();
    nrst = 1'b0;
    drive(1, 4'd7, 16'h7777, 1, 4'd2, 4'd7, 4'd2);
    cyc();
    nrst = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd7, 4'd2);
    sample();
    check("rst_mid_r7", 32'(reg_data[7]), 32'h0);
    check("rst_mid_pending", 32'(pend), 32'h0);
    commit();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_regfile_mp
